dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the shared data memory. It lets the core's load/store unit (port 0) and the debug/DMA loader (port 1) share one data memory instance. It arbitrates round-robin, latches the winning request, and drives the memory's address, write-enable and write-data for exactly one cycle. It then returns a registered read result with a one-cycle acknowledge to the winner. It sits between both requesters and the memory; no other block drives the memory ports.

## Interface
- DATA_WIDTH, 8, width of data words and of the memory address bus
- DATA_LEN, 256, number of implemented memory words; addresses ≥ DATA_LEN are rejected
- clk  in  1  system clock, all state updates on rising edge
- nReset  in  1  reset, synchronous, active-low
- req0 / req1  in  1  access request; held high with stable we/addr/wdata until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  DATA_WIDTH  word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = address out of range, no memory access performed
- rdata  out  DATA_WIDTH  registered read data, valid with ack on reads
- busy  out  1  high in ACCESS and RESP
- mem_addr  out  DATA_WIDTH  to memory address
- mem_we  out  1  to memory write enable, high only in ACCESS for an in-range write
- mem_wdata  out  DATA_WIDTH  to memory write data
- mem_rdata  in  DATA_WIDTH  from memory combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick the winner, latch its id, we, addr and wdata, compute the out-of-range flag (addr ≥ DATA_LEN), and go to ACCESS.
- Round-robin arbitration:
  - If only one port requests, it wins.
  - If both request, the port not granted last wins.
  - last_grant updates on each grant.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_we = latched we AND in-range.
  - For an in-range read, capture mem_rdata into rdata at the end of the cycle.
  - Writes and out-of-range accesses leave rdata unchanged.
  - Always go to RESP.
- RESP:
  - Assert ack for the latched id only, and drive err from the latched flag.
  - Go to IDLE.
- The requester may drop or change req at the edge ending its ack cycle. IDLE samples the new request on the next cycle.
- mem_addr and mem_wdata hold their last values outside ACCESS. mem_we is 0 outside ACCESS.
- Requests arriving during ACCESS or RESP are ignored until IDLE; a held req is never lost.
- A req deasserted before its ack violates the protocol. Behaviour is undefined and is not checked.

## Timing
- Reset values when nReset=0 at an edge:
  - FSM = IDLE.
  - ack0, ack1, err, busy, mem_we = 0.
  - rdata, mem_addr, mem_wdata = 0.
  - last_grant = port 1, so port 0 wins the first contention.
- Latency: req sampled in IDLE at cycle N, memory access in cycle N+1, ack in cycle N+2.
- Throughput: one access per 3 cycles. Continuous contention alternates 0,1,0,1.
- Simultaneous req0 and req1 in IDLE: the round-robin rule applies; the loser waits exactly 3 cycles.
- Reset mid-ACCESS: mem_we is 0 from the reset cycle onward. A write already presented at that edge may complete. No ack is produced.
- Reset mid-RESP: the ack pulse is suppressed from the reset cycle onward.
- addr = DATA_LEN-1 is in range. addr = DATA_LEN (when DATA_LEN < 2^DATA_WIDTH) is out of range: err=1 and mem_we stays 0.

## Structure
- Package dmem_arb_pkg:
  - State enum state_t {IDLE, ACCESS, RESP}.
  - Port id constants PORT_CORE=0 and PORT_DBG=1.
- Sub-module dmem_rr_pick: combinational 2-way round-robin pick.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
- The top level holds the FSM, the latch registers and rdata.

## Test plan
- Reset, then req0 read, addr=0x05, memory model preloaded with mem[i]=i → ack0 at cycle N+2, rdata=0x05, err=0; mem_we never high.
- req1 write, addr=0x10, wdata=0xA5 → mem_we high for exactly one cycle with mem_addr=0x10 and mem_wdata=0xA5. Then ack1 with err=0, and rdata unchanged. A following read of 0x10 returns 0xA5.
- req0 and req1 both held high after reset, 4 accesses → grant order 0,1,0,1; acks 3 cycles apart.
- DATA_LEN=200, req0 read at addr=200 → ack0 with err=1; mem_we=0 throughout; rdata unchanged. addr=199 → err=0.
- nReset driven low during ACCESS of a write → no ack, FSM in IDLE, all outputs at reset values next cycle. The next contention grants port 0 first.
- req0 re-asserted immediately after ack0 while req1 is pending → port 1 is granted next.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Access sequencer states: wait for a request, drive the memory, acknowledge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identities as carried in the grant/latched-id registers.
    localparam logic PORT_CORE = 1'b0;  // core load/store unit
    localparam logic PORT_DBG  = 1'b1;  // debug / DMA loader

endpackage : dmem_arb_pkg

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin pick.
// A lone requester always wins; under contention the port that was not
// granted last time wins, so continuous contention alternates.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Select the winner from the current requests and the previous grant.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT_CORE;
        if (req0 && req1) begin
            grant_id = (last_grant == PORT_CORE) ? PORT_DBG : PORT_CORE;
        end else if (req1) begin
            grant_id = PORT_DBG;
        end
    end

endmodule : dmem_rr_pick

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the shared data memory.
// One access takes three cycles: IDLE (arbitrate and latch), ACCESS (drive
// the memory for one cycle), RESP (one-cycle ack to the winner).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Memory size widened so the range test works for any DATA_WIDTH up to 64.
    localparam logic [63:0] LEN_EXT = 64'(DATA_LEN);

    // Addresses at or beyond the implemented depth never reach the memory.
    function automatic logic out_of_range(input logic [DATA_WIDTH-1:0] a);
        logic [63:0] a_ext;
        a_ext = 64'(a);
        return (a_ext >= LEN_EXT);
    endfunction

    state_t                  state;
    state_t                  state_next;

    logic                    last_grant;
    logic                    grant_valid;
    logic                    grant_id;

    logic                    sel_we;
    logic [DATA_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    logic                    lat_id;
    logic                    lat_we;
    logic                    lat_oor;
    logic [DATA_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    logic                    grant_take;

    dmem_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Route the winning port's request fields toward the latch registers.
    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (grant_id == PORT_DBG) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // A grant is only taken while idle; requests during ACCESS/RESP just wait.
    assign grant_take = (state == IDLE) && grant_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state memory/handshake outputs. Outputs are gated
    // by nReset so a reset asserted mid-ACCESS or mid-RESP silences the
    // write strobe and the ack in that same cycle.
    always_comb begin
        state_next = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err        = 1'b0;
        busy       = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy       = 1'b1;
                mem_we     = nReset & lat_we & ~lat_oor;
                state_next = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                if (nReset) begin
                    ack0 = (lat_id == PORT_CORE);
                    ack1 = (lat_id == PORT_DBG);
                    err  = lat_oor;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winning request and remember who was granted for fairness.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            last_grant <= PORT_DBG;
            lat_id     <= PORT_CORE;
            lat_we     <= 1'b0;
            lat_oor    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (grant_take) begin
            last_grant <= grant_id;
            lat_id     <= grant_id;
            lat_we     <= sel_we;
            lat_oor    <= out_of_range(sel_addr);
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
        end
    end

    // Capture read data at the end of an in-range read access; writes and
    // rejected accesses leave the previous result in place.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            rdata <= '0;
        end else if ((state == ACCESS) && !lat_we && !lat_oor) begin
            rdata <= mem_rdata;
        end
    end

    // The latched address/data only change on a grant, so the memory bus
    // holds its last values outside ACCESS.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule : dmem_arbiter
